// File: rtl/mod_counter_pkg.sv
// Shared types and next-state helpers for the programmable-modulus up/down counter.
package mod_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Widest counter the 32-bit helper arithmetic supports with one spare bit.
  localparam int unsigned MAX_WIDTH = 31;

  // Result of one count step: next value plus rollover flag.
  typedef struct packed {
    logic [31:0] value;
    logic        wrap;
  } count_step_t;

  // Parallel-load value, clamped into the legal count range.
  function automatic logic [31:0] clamp_load(logic [31:0] d, logic [31:0] modulus);
    return (d < modulus) ? d : (modulus - 32'd1);
  endfunction

  // Next count in the given direction with modular wrap and wrap flag.
  function automatic count_step_t next_count(logic [31:0] q, logic up, logic [31:0] modulus);
    count_step_t r;
    r.value = q;
    r.wrap  = 1'b0;
    if (up == DIR_UP) begin
      if (q == (modulus - 32'd1)) begin
        r.value = 32'd0;
        r.wrap  = 1'b1;
      end else begin
        r.value = q + 32'd1;
      end
    end else begin
      if (q == 32'd0) begin
        r.value = modulus - 32'd1;
        r.wrap  = 1'b1;
      end else begin
        r.value = q - 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, clamped parallel load, CEP/CET
// enables, combinational cascade terminal count and registered wrap pulse.
// Build option: define MOD_COUNTER_SAT_EN to saturate at the range ends
// instead of wrapping (Wrap is then tied low).
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             CEP,
  input  logic             CET,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  // Reject parameter sets outside the supported range at elaboration.
  if (WIDTH < 1 || WIDTH > MAX_WIDTH || MODULUS < 2 ||
      64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_param
    $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
  end

  count_step_t      step;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  // Next-state selection: load beats count beats hold.
  always_comb begin
    step     = next_count(32'(Q), Up, 32'(MODULUS));
    q_nxt    = Q;
    wrap_nxt = 1'b0;
    if (Load) begin
      q_nxt = WIDTH'(clamp_load(32'(D), 32'(MODULUS)));
    end else if (CEP && CET) begin
`ifdef MOD_COUNTER_SAT_EN
      // A step that would roll over is suppressed, leaving Q pinned at the end.
      if (!step.wrap) begin
        q_nxt = WIDTH'(step.value);
      end
`else
      q_nxt    = WIDTH'(step.value);
      wrap_nxt = step.wrap;
`endif
    end
  end

  // Count register; MR clears it asynchronously and discards any pending load.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      Q    <= '0;
      Wrap <= 1'b0;
    end else begin
      Q    <= q_nxt;
      Wrap <= wrap_nxt;
    end
  end

  // Terminal count is combinational so the next stage's CET sees it this cycle.
  assign TC = CET & ((Up == DIR_UP) ? (Q == MAX_Q) : (Q == '0));

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down counter with programmable modulus, parallel load, count enables and cascade-ready terminal count.
- Successor to the fixed 4-bit binary counter with master reset and terminal count.
- Used stand-alone (dividers, timers) or chained through CET/TC to build wider or BCD-style counters.

Parameters:
- WIDTH, 4, bit width of D and Q.
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2..2**WIDTH; an elaboration-time check rejects anything else.

Ports:
- Clk  input  1  rising-edge clock.
- MR  input  1  master reset: asynchronous assert, active-low; release is synchronised externally.
- CEP  input  1  count enable, local.
- CET  input  1  count enable, cascade input; also gates TC.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Load  input  1  synchronous parallel load strobe.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  count value.
- TC  output  1  terminal count, combinational.
- Wrap  output  1  registered one-cycle pulse on rollover.

Behaviour:
- Reset:
  - MR=0 forces Q=0 and Wrap=0 immediately, independent of Clk.
  - All inputs are ignored while MR=0.
  - First count edge is the first rising Clk after MR returns to 1.
- Per rising Clk, priority is Load > count > hold.
- Load=1:
  - Q <= D when D < MODULUS; otherwise Q <= MODULUS-1 (clamp).
  - Wrap <= 0.
  - CEP, CET and Up are ignored.
- Count (Load=0, CEP=1, CET=1):
  - Up=1: Q <= (Q==MODULUS-1) ? 0 : Q+1.
  - Up=0: Q <= (Q==0) ? MODULUS-1 : Q-1.
  - Wrap <= 1 exactly when a wrap transition occurs; otherwise 0.
- Hold (Load=0, CEP=0 or CET=0): Q unchanged, Wrap <= 0.
- TC = CET & (Up ? Q==MODULUS-1 : Q==0).
  - Combinational, so a cascade stage's CET sees it in the same cycle.
  - TC does not depend on CEP (74x161 semantics).
- Direction change mid-count takes effect on the next edge; no state is lost.
- Latency: Q updates 1 cycle after the enabling edge. Wrap is asserted in the same cycle Q shows the wrapped value.
- Arithmetic is internally WIDTH+1 bits. When MODULUS=2**WIDTH, wrap equals natural binary overflow.
- MR asserted mid-count or mid-load: Q=0 and Wrap=0 at once; the pending load is discarded.

Optional Feature:
- Macro: MOD_COUNTER_SAT_EN.
- Defined:
  - Counting saturates: up-count holds at MODULUS-1, down-count holds at 0.
  - Wrap never asserts; it is tied to 0.
  - TC keeps the same definition, so it stays high while the counter is saturated and CET=1.
- Undefined: wrap-around behaviour as specified above.
- Load, reset and TC behaviour are identical in both builds.

Decomposition:
- Package mod_counter_pkg holds:
  - direction constants DIR_UP=1'b1 and DIR_DN=1'b0;
  - function clamp_load(d, modulus);
  - function next_count(q, up, modulus), which returns the next value and a wrap flag.
- No sub-module: next-state logic is a single combinational block plus one register stage.
- A separate wrapper, mod_counter_chain, instantiates N stages with TC->CET chaining; it is out of scope for this block.

Test Plan:
- Reset: WIDTH=4, MODULUS=10. Drive MR=0 at t=10ns, release at 20ns, CEP=CET=Up=1. Expect:
  - Q counts 0..9;
  - Q returns to 0 on the 10th edge with Wrap=1 for that one cycle;
  - TC=1 only while Q=9.
- Down-count: Up=0 from Q=0 → next Q=9 with Wrap=1. TC=1 while Q=0 and CET=1; TC=0 when CET=0.
- Load priority: Q=3, Load=1, D=7, CEP=1 → Q=7, Wrap=0. With D=12 and MODULUS=10 → Q=9 (clamp).
- Enables: CEP=0, CET=1 at Q=9, Up=1 → Q holds at 9 and TC=1. CET=0 → Q holds and TC=0.
- Async reset mid-operation: assert MR=0 between clock edges while Q=6 → Q=0 and Wrap=0 before the next edge. Counting resumes from 0 after release.
- MOD_COUNTER_SAT_EN build, MODULUS=10:
  - up-count from 8 → 9, 9, 9 with Wrap=0 and TC=1;
  - down from 1 → 0, 0 with TC=1.
